// File: rtl/axi_lite_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read channel (AR/R) between two
// read masters and a single downstream slave. Exactly one read is kept in
// flight, and its response is steered back to the requester that was granted.
module axi_lite_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                areset,
  // Upstream requesters, bit/slice i belongs to requester i
  input  logic [1:0]          s_arvalid,
  input  logic [2*ADDR_W-1:0] s_araddr,
  output logic [1:0]          s_arready,
  output logic [1:0]          s_rvalid,
  input  logic [1:0]          s_rready,
  output logic [2*DATA_W-1:0] s_rdata,
  output logic [3:0]          s_rresp,
  // Downstream slave
  output logic                m_arvalid,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_arready,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              m_arvalid_q, m_arvalid_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;

  logic              winner;
  logic [ADDR_W-1:0] winner_addr;

  // Round-robin pick: on contention the requester not served last time wins
  always_comb begin
    winner = 1'b0;
    if (&s_arvalid) begin
      winner = ~last_grant_q;
    end else if (s_arvalid[1]) begin
      winner = 1'b1;
    end
    winner_addr = winner ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
  end

  // Next-state logic: accept in IDLE, issue downstream in ADDR, return data in DATA
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_arvalid_d  = m_arvalid_q;
    m_araddr_d   = m_araddr_q;
    case (state_q)
      IDLE: begin
        if (|s_arvalid) begin
          grant_d     = winner;
          m_araddr_d  = winner_addr;
          m_arvalid_d = 1'b1;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (m_rvalid && s_rready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: begin
        m_arvalid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State registers; reset wins over any handshake on the same edge
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m_arvalid_q  <= 1'b0;
      m_araddr_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_arvalid_q  <= m_arvalid_d;
      m_araddr_q   <= m_araddr_d;
    end
  end

  // Acceptance is only offered to the winner, and never while reset is held
  assign s_arready = (state_q == IDLE && !areset && (|s_arvalid)) ?
                     (winner ? 2'b10 : 2'b01) : 2'b00;

  // Response path is steered to the granted requester only during DATA
  assign s_rvalid  = (state_q == DATA && m_rvalid) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign m_rready  = (state_q == DATA) && s_rready[grant_q];
  assign s_rdata   = {2{m_rdata}};
  assign s_rresp   = {2{m_rresp}};

  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = m_araddr_q;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Self-checking bench for the two-requester AXI4-Lite read arbiter. The bench
// plays both requesters and the downstream slave, and a transaction-level
// reference model predicts every handshake and routed response.
module tb_axi_lite_rd_arbiter;

   logic        aclk = 1'b0;
   logic        areset;
   logic [1:0]  s_arvalid;
   logic [63:0] s_araddr;
   logic [1:0]  s_arready;
   logic [1:0]  s_rvalid;
   logic [1:0]  s_rready;
   logic [63:0] s_rdata;
   logic [3:0]  s_rresp;
   logic        m_arvalid;
   logic [31:0] m_araddr;
   logic        m_arready;
   logic        m_rvalid;
   logic        m_rready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;

   axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s_arvalid (s_arvalid),
      .s_araddr  (s_araddr),
      .s_arready (s_arready),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .m_arvalid (m_arvalid),
      .m_araddr  (m_araddr),
      .m_arready (m_arready),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp)
   );

   // Free-running 10 ns clock
   always #5 aclk = ~aclk;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: a read is "busy" from upstream acceptance until the R
   // handshake, and "arDone" once the downstream slave has taken the address.
   bit          busy      = 1'b0;
   bit          arDone    = 1'b0;
   bit          owner     = 1'b0;
   bit          lastGrant = 1'b1;
   logic [31:0] expAddr   = '0;
   int          grantLog[$];
   logic [31:0] addrLog[$];

   // Stimulus knobs: percentages for random behaviour plus fixed-value options
   int          pReq[2]    = '{0, 0};
   int          pRready[2] = '{100, 100};
   int          pArready   = 100;
   int          pRvalid    = 100;
   bit          useFixAddr = 1'b0;
   logic [31:0] fixAddr[2] = '{32'h0, 32'h0};
   bit          useFixData = 1'b1;
   logic [31:0] fixData    = 32'h0;
   bit          randResp   = 1'b0;
   logic [1:0]  respVal    = 2'b00;
   bit          doReset    = 1'b0;

   // Last outputs seen at the falling edge, for the directed checks
   logic [1:0]  obsArready;
   logic        obsArvalid;
   logic [31:0] obsAraddr;
   logic [1:0]  obsRvalid;
   logic        obsMrready;
   logic [63:0] obsRdata;
   logic [3:0]  obsRresp;

   // One comparison: count it and report a mismatch with both values
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One full clock cycle: drive inputs, check outputs against the model at
   // the falling edge, then advance the model by the handshakes it predicted.
   task automatic applyStimulus();
      logic [1:0] expArready;
      logic [1:0] expRvalid;
      bit         win;
      bit         accepted;
      bit         arHs;
      bit         rHs;
      areset = doReset;
      for (int i = 0; i < 2; i++) begin
         if (!s_arvalid[i] && $urandom_range(99) < pReq[i]) begin
            s_arvalid[i] = 1'b1;
            s_araddr[i*32 +: 32] = useFixAddr ? fixAddr[i] : $urandom;
         end
         s_rready[i] = ($urandom_range(99) < pRready[i]);
      end
      m_arready = ($urandom_range(99) < pArready);
      if (busy && arDone && !m_rvalid && $urandom_range(99) < pRvalid) begin
         m_rvalid = 1'b1;
         m_rdata  = useFixData ? fixData : $urandom;
         m_rresp  = randResp ? 2'($urandom_range(3)) : respVal;
      end

      @(negedge aclk);
      win = (s_arvalid == 2'b11) ? ~lastGrant : s_arvalid[1];
      expArready = (!busy && !areset && s_arvalid != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
      expRvalid  = (busy && arDone && m_rvalid) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      checkOutput("s_arready", 64'(s_arready), 64'(expArready));
      checkOutput("m_arvalid", 64'(m_arvalid), 64'(busy && !arDone));
      if (busy && !arDone) checkOutput("m_araddr", 64'(m_araddr), 64'(expAddr));
      checkOutput("s_rvalid", 64'(s_rvalid), 64'(expRvalid));
      checkOutput("m_rready", 64'(m_rready), 64'(busy && arDone && s_rready[owner]));
      if (expRvalid != 2'b00) begin
         checkOutput("s_rdata", 64'(s_rdata[owner*32 +: 32]), 64'(m_rdata));
         checkOutput("s_rresp", 64'(s_rresp[owner*2 +: 2]), 64'(m_rresp));
      end
      obsArready = s_arready;
      obsArvalid = m_arvalid;
      obsAraddr  = m_araddr;
      obsRvalid  = s_rvalid;
      obsMrready = m_rready;
      obsRdata   = s_rdata;
      obsRresp   = s_rresp;
      accepted = (expArready != 2'b00);
      arHs     = busy && !arDone && m_arready;
      rHs      = busy && arDone && m_rvalid && s_rready[owner];

      @(posedge aclk);
      #1;
      if (areset) begin
         busy      = 1'b0;
         arDone    = 1'b0;
         lastGrant = 1'b1;
         s_arvalid = 2'b00;
         m_rvalid  = 1'b0;
      end else begin
         if (rHs) begin
            busy      = 1'b0;
            arDone    = 1'b0;
            lastGrant = owner;
            m_rvalid  = 1'b0;
         end
         if (arHs) begin
            arDone = 1'b1;
            addrLog.push_back(expAddr);
         end
         if (accepted) begin
            busy    = 1'b1;
            arDone  = 1'b0;
            owner   = win;
            expAddr = s_araddr[win*32 +: 32];
            s_arvalid[win] = 1'b0;
            grantLog.push_back(int'(win));
         end
      end
   endtask

   // Run until nothing is outstanding or pending, within a cycle budget
   task automatic drainIdle(input string tag, input int budget);
      int n = 0;
      while ((busy || s_arvalid != 2'b00) && n < budget) begin
         applyStimulus();
         n++;
      end
      if (busy || s_arvalid != 2'b00) checkOutput(tag, 64'(n), 64'(budget + 1));
   endtask

   // Run until the downstream address phase has completed, within a budget
   task automatic waitArDone(input string tag, input int budget);
      int n = 0;
      while (!(busy && arDone) && n < budget) begin
         applyStimulus();
         n++;
      end
      if (!(busy && arDone)) checkOutput(tag, 64'(n), 64'(budget + 1));
   endtask

   // Hold reset for one checked cycle and release it
   task automatic pulseReset();
      doReset = 1'b1;
      applyStimulus();
      doReset = 1'b0;
   endtask

   initial begin
      bit sawErr;
      int n;
      areset    = 1'b1;
      s_arvalid = 2'b00;
      s_araddr  = '0;
      s_rready  = 2'b00;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      m_rresp   = 2'b00;
      repeat (2) @(posedge aclk);
      #1;

      // Reset state: nothing offered, nothing issued, address cleared
      pulseReset();
      applyStimulus();
      checkOutput("rst_arvalid", 64'(obsArvalid), 64'd0);
      checkOutput("rst_araddr", 64'(obsAraddr), 64'd0);
      checkOutput("rst_rvalid", 64'(obsRvalid), 64'd0);
      checkOutput("rst_mrready", 64'(obsMrready), 64'd0);

      // Single read from requester 0 against a zero-wait slave
      fixData = 32'hDEAD_BEEF;
      s_arvalid = 2'b01;
      s_araddr[31:0] = 32'h0000_1000;
      applyStimulus();
      checkOutput("single_c0_arready", 64'(obsArready), 64'h1);
      applyStimulus();
      checkOutput("single_c1_arvalid", 64'(obsArvalid), 64'h1);
      checkOutput("single_c1_araddr", 64'(obsAraddr), 64'h1000);
      applyStimulus();
      checkOutput("single_c2_rvalid", 64'(obsRvalid), 64'h1);
      checkOutput("single_c2_rdata", 64'(obsRdata[31:0]), 64'hDEAD_BEEF);
      drainIdle("single_drain_timeout", 10);

      // Contention: both requesters always valid, grants must alternate
      pulseReset();
      grantLog.delete();
      addrLog.delete();
      useFixAddr = 1'b1;
      fixAddr[0] = 32'h10;
      fixAddr[1] = 32'h20;
      useFixData = 1'b0;
      pReq[0] = 100;
      pReq[1] = 100;
      n = 0;
      while (addrLog.size() < 6 && n < 60) begin
         applyStimulus();
         n++;
      end
      pReq[0] = 0;
      pReq[1] = 0;
      if (addrLog.size() < 6) checkOutput("contention_timeout", 64'(addrLog.size()), 64'd6);
      for (int k = 0; k < 6 && k < addrLog.size(); k++) begin
         checkOutput($sformatf("contention_grant%0d", k), 64'(grantLog[k]), 64'(k % 2));
         checkOutput($sformatf("contention_addr%0d", k), 64'(addrLog[k]),
                     (k % 2 == 1) ? 64'h20 : 64'h10);
      end
      drainIdle("contention_drain_timeout", 20);
      useFixAddr = 1'b0;

      // AR backpressure: address must hold steady while the slave stalls
      pArready = 0;
      s_arvalid = 2'b01;
      s_araddr[31:0] = 32'hA5A5_0000;
      applyStimulus();
      for (int k = 0; k < 5; k++) begin
         applyStimulus();
         checkOutput($sformatf("arbp_arvalid%0d", k), 64'(obsArvalid), 64'h1);
         checkOutput($sformatf("arbp_araddr%0d", k), 64'(obsAraddr), 64'hA5A5_0000);
      end
      pArready = 100;
      drainIdle("arbp_drain_timeout", 10);

      // R backpressure on requester 1: data holds, no new AR accepted
      useFixData = 1'b1;
      fixData = 32'h1234_5678;
      pRready[1] = 0;
      s_arvalid = 2'b10;
      s_araddr[63:32] = 32'h0000_3000;
      waitArDone("rbp_ar_timeout", 10);
      s_arvalid[0] = 1'b1;
      s_araddr[31:0] = 32'h0000_3100;
      for (int k = 0; k < 4; k++) begin
         applyStimulus();
         checkOutput($sformatf("rbp_mrready%0d", k), 64'(obsMrready), 64'h0);
         checkOutput($sformatf("rbp_arready%0d", k), 64'(obsArready), 64'h0);
         checkOutput($sformatf("rbp_rdata%0d", k), 64'(obsRdata[63:32]), 64'h1234_5678);
      end
      pRready[1] = 100;
      drainIdle("rbp_drain_timeout", 20);

      // Error response on requester 1 passes through unmodified
      respVal = 2'b10;
      s_arvalid = 2'b10;
      s_araddr[63:32] = 32'h0000_6000;
      sawErr = 1'b0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus();
         if (obsRvalid[1]) begin
            checkOutput("err_rresp", 64'(obsRresp[3:2]), 64'h2);
            sawErr = 1'b1;
         end
      end
      if (!sawErr) checkOutput("err_seen", 64'd0, 64'd1);
      respVal = 2'b00;
      drainIdle("err_drain_timeout", 10);
      s_arvalid = 2'b01;
      s_araddr[31:0] = 32'h0000_6100;
      applyStimulus();
      checkOutput("err_next_arready", 64'(obsArready), 64'h1);
      drainIdle("err_next_drain_timeout", 10);

      // Reset while waiting for the downstream address handshake
      pArready = 0;
      s_arvalid = 2'b10;
      s_araddr[63:32] = 32'h0000_4000;
      applyStimulus();
      applyStimulus();
      pulseReset();
      pArready = 100;
      applyStimulus();
      checkOutput("rst_addr_arvalid", 64'(obsArvalid), 64'h0);
      checkOutput("rst_addr_mrready", 64'(obsMrready), 64'h0);

      // Reset while the response is being held off by the requester
      pRready[0] = 0;
      pRready[1] = 0;
      s_arvalid = 2'b10;
      s_araddr[63:32] = 32'h0000_5000;
      waitArDone("rst_data_ar_timeout", 10);
      applyStimulus();
      pulseReset();
      pRready[0] = 100;
      pRready[1] = 100;
      applyStimulus();
      checkOutput("rst_data_arvalid", 64'(obsArvalid), 64'h0);
      checkOutput("rst_data_mrready", 64'(obsMrready), 64'h0);
      s_arvalid = 2'b11;
      s_araddr = {32'h0000_7100, 32'h0000_7000};
      applyStimulus();
      checkOutput("rst_first_grant", 64'(obsArready), 64'h1);
      drainIdle("rst_drain_timeout", 20);

      // Randomized traffic, backpressure and occasional resets
      useFixData = 1'b0;
      randResp   = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) begin
            pReq[0]    = $urandom_range(100);
            pReq[1]    = $urandom_range(100);
            pArready   = $urandom_range(100, 10);
            pRvalid    = $urandom_range(100, 10);
            pRready[0] = $urandom_range(100, 10);
            pRready[1] = $urandom_range(100, 10);
         end
         doReset = ($urandom_range(199) == 0);
         applyStimulus();
         doReset = 1'b0;
      end
      pReq[0] = 0;
      pReq[1] = 0;
      pArready = 100;
      pRvalid = 100;
      pRready[0] = 100;
      pRready[1] = 100;
      drainIdle("random_drain_timeout", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/axi_lite_rd_arbiter.md
# axi_lite_rd_arbiter

Round-robin arbiter sharing one AXI4-Lite read channel (AR/R) between two requesting masters. It sits between two AXI4-Lite read masters (e.g. the stimulus master and the pass-through VIP in run-time master mode) and a single downstream slave. It keeps exactly one read outstanding and routes the response back to the granted requester.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- s_arvalid  in  2  per-requester AR valid; bit i = requester i
- s_araddr  in  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]
- s_arready  out  2  per-requester AR ready
- s_rvalid  out  2  per-requester R valid
- s_rready  in  2  per-requester R ready
- s_rdata  out  2*DATA_W  R data; both slices carry m_rdata
- s_rresp  out  4  R response; both 2-bit slices carry m_rresp
- m_arvalid  out  1  downstream AR valid
- m_araddr  out  ADDR_W  downstream AR address, registered
- m_arready  in  1  downstream AR ready
- m_rvalid  in  1  downstream R valid
- m_rready  out  1  downstream R ready
- m_rdata  in  DATA_W  downstream R data
- m_rresp  in  2  downstream R response

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If no s_arvalid is set, stay in IDLE.
  - Otherwise pick the grant g by round robin: the requester that is not last_grant wins when both are valid; if only one is valid, that one wins.
  - s_arready[g] = 1 combinationally in this cycle, and only for g.
  - On the clock edge, capture s_araddr slice g into m_araddr, register g, and go to ADDR.
- ADDR:
  - m_arvalid = 1 and m_araddr holds stable.
  - On m_arvalid & m_arready, go to DATA.
- DATA:
  - s_rvalid[g] = m_rvalid and m_rready = s_rready[g], both combinational. The other requester sees s_rvalid = 0.
  - On m_rvalid & s_rready[g], set last_grant := g and go to IDLE.
- s_arready is 0 in ADDR and DATA. A requester holding s_arvalid waits, as AXI requires it to keep valid asserted.
- Only one transaction is in flight. No reordering is possible; rresp passes through unmodified, including SLVERR/DECERR.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1, so requester 0 wins the first contention.
  - m_arvalid = 0, m_araddr = 0, m_rready = 0.
  - s_arready = 0 while in reset; s_rvalid = 0.
- Latency, zero-wait slave:
  - Cycle 0: AR accepted from the requester.
  - Cycle 1: m_arvalid = 1, m_arready = 1.
  - Cycle 2: DATA; R handshake if m_rvalid = 1.
  - Cycle 3: IDLE, next request accepted.
  - Minimum issue interval is therefore 3 cycles.
- Simultaneous requests in IDLE: exactly one s_arready bit is ever set. Alternation is strict while both requesters stay valid.
- The R handshake and a new s_arvalid in the same cycle: the new request is not accepted until the following IDLE cycle.
- Backpressure: m_arvalid and m_araddr stay stable indefinitely while m_arready = 0. m_rvalid is held pending while s_rready[g] = 0.
- areset in any state: return to IDLE next edge and drop m_arvalid and m_rready.
  - The in-flight transaction is abandoned.
  - The downstream slave and the requesters must be reset in the same cycle.
- areset has priority over every handshake sampled on the same edge.

## Test plan
- Single request: requester 0 reads 0x0000_1000; slave returns 0xDEAD_BEEF/OKAY with zero wait. Required:
  - s_arready[0] high at cycle 0.
  - m_arvalid with addr 0x1000 at cycle 1.
  - s_rvalid[0] with 0xDEAD_BEEF at cycle 2; s_rvalid[1] stays 0.
- Contention: both requesters valid continuously for 6 reads (addresses 0x10 for requester 0, 0x20 for requester 1). Required:
  - Grants go 0,1,0,1,0,1.
  - m_araddr goes 0x10,0x20,…
  - Each rdata returns only to the matching requester.
- Backpressure:
  - m_arready held 0 for 5 cycles: m_arvalid and m_araddr are stable for all 5 cycles.
  - s_rready[1] held 0 for 4 cycles: m_rready = 0, data holds, and no new AR is accepted.
- Error response: slave returns rresp = 2'b10 for requester 1. Required: s_rresp[3:2] = 2'b10 when s_rvalid[1] = 1; the arbiter returns to IDLE normally.
- Reset mid-operation: assert areset in ADDR and again in DATA. Required:
  - Next cycle: state IDLE, m_arvalid = 0, m_rready = 0.
  - The following request, with both requesters valid, is granted to requester 0.
